// File: rtl/malzeme_dagitici_pkg.sv
// Shared types and constants for the ingredient dispenser (malzeme_dagitici).
// Holds the FSM state enum, hopper index constants and the phase timer width.
// Optional build macro used by the top: DAGITICI_SAYAC_EN (dose counter).
package dagitici_pkg;

    typedef enum logic [2:0] {
        BOSTA,
        TUZ,
        ACIK,
        ARA,
        BITIR
    } durum_t;

    localparam int HAZNE_A = 0;
    localparam int HAZNE_B = 1;
    localparam int ZAMAN_W = 4;

    // One-hot valve pattern for the selected hopper.
    function automatic logic [1:0] tek_sicak(input logic sec);
        logic [1:0] r;
        r          = '0;
        r[HAZNE_A] = ~sec;
        r[HAZNE_B] = sec;
        return r;
    endfunction

endpackage

// File: rtl/malzeme_dagitici_if.sv
// Order handshake between the ingredient-selection stage and the dispenser.
// One order (hopper, unit count, salt flag) is transferred when valid and hazir meet.
// master = upstream producer, slave = dispenser.
interface malzeme_dagitici_if;
    logic       bitti_giris;
    logic       secilen_malzeme;
    logic [3:0] malzeme_miktari;
    logic       cikis_tuzlu;
    logic       hazir;

    modport master (
        output bitti_giris,
        output secilen_malzeme,
        output malzeme_miktari,
        output cikis_tuzlu,
        input  hazir
    );

    modport slave (
        input  bitti_giris,
        input  secilen_malzeme,
        input  malzeme_miktari,
        input  cikis_tuzlu,
        output hazir
    );
endinterface

// File: rtl/malzeme_dagitici_darbe_zamanlayici.sv
// Loadable down-counter timing one valve-open or gap phase.
// Latency: flag is high in the last cycle of a phase loaded with (length-1).
// Backpressure: i_durdur freezes the count; a load always wins over the hold.
module darbe_zamanlayici
    import dagitici_pkg::*;
(
    input  logic               saat,
    input  logic               reset,
    input  logic               i_yukle,
    input  logic [ZAMAN_W-1:0] i_deger,
    input  logic               i_durdur,
    output logic               o_bitti_darbe
);

    logic [ZAMAN_W-1:0] r_sayac;

    // Load on phase entry, otherwise count down to zero unless paused.
    always_ff @(posedge saat or posedge reset) begin
        if (reset) begin
            r_sayac <= '0;
        end else if (i_yukle) begin
            r_sayac <= i_deger;
        end else if (!i_durdur && (r_sayac != '0)) begin
            r_sayac <= r_sayac - 1'b1;
        end
    end

    assign o_bitti_darbe = (r_sayac == '0);

endmodule

// File: rtl/malzeme_dagitici.sv
// Dispenser: turns one order into timed valve pulses (salt dose first, then N units).
// Latency: tamam in cycle U*VANA_ACIK + max(U-1,0)*BOSLUK + 1 after capture, U = N + salt.
// Backpressure: hazir only in BOSTA; durdur freezes timer/kalan and closes valves.
// Build macro DAGITICI_SAYAC_EN adds the saturating toplam_doz dose counter.
module malzeme_dagitici
    import dagitici_pkg::*;
#(
    parameter int VANA_ACIK = 2,
    parameter int BOSLUK    = 1
) (
    input  logic                 saat,
    input  logic                 reset,
    malzeme_dagitici_if.slave    siparis,
    input  logic                 durdur,
    output logic [1:0]           vana,
    output logic                 tuz_vana,
    output logic [3:0]           kalan,
    output logic                 tamam
`ifdef DAGITICI_SAYAC_EN
    ,
    output logic [7:0]           toplam_doz
`endif
);

    localparam logic [ZAMAN_W-1:0] ACIK_YUK = ZAMAN_W'(VANA_ACIK - 1);
    localparam logic [ZAMAN_W-1:0] ARA_YUK  = ZAMAN_W'((BOSLUK > 0) ? BOSLUK - 1 : 0);

    durum_t             r_durum;
    durum_t             w_durum_nxt;
    logic               r_sel;
    logic [3:0]         r_kalan;
    logic               w_yakala;
    logic               w_faz_son;
    logic               w_yukle;
    logic [ZAMAN_W-1:0] w_yukle_deger;
    logic               w_kalan_azalt;
    logic               w_doz_bitti;
    logic               w_bitti_darbe;

    darbe_zamanlayici u_zamanlayici (
        .saat          (saat),
        .reset         (reset),
        .i_yukle       (w_yukle),
        .i_deger       (w_yukle_deger),
        .i_durdur      (durdur),
        .o_bitti_darbe (w_bitti_darbe)
    );

    assign w_yakala  = (r_durum == BOSTA) && siparis.bitti_giris;
    // A phase ends on the edge of its last cycle, but never while paused.
    assign w_faz_son = w_bitti_darbe && !durdur;

    // State register.
    always_ff @(posedge saat or posedge reset) begin
        if (reset) begin
            r_durum <= BOSTA;
        end else begin
            r_durum <= w_durum_nxt;
        end
    end

    // Next state, timer reload and per-dose strobes.
    always_comb begin
        w_durum_nxt   = r_durum;
        w_yukle       = 1'b0;
        w_yukle_deger = '0;
        w_kalan_azalt = 1'b0;
        w_doz_bitti   = 1'b0;
        case (r_durum)
            BOSTA: begin
                if (w_yakala) begin
                    if (siparis.cikis_tuzlu) begin
                        w_durum_nxt   = TUZ;
                        w_yukle       = 1'b1;
                        w_yukle_deger = ACIK_YUK;
                    end else if (siparis.malzeme_miktari != 4'd0) begin
                        w_durum_nxt   = ACIK;
                        w_yukle       = 1'b1;
                        w_yukle_deger = ACIK_YUK;
                    end else begin
                        w_durum_nxt   = BITIR;
                    end
                end
            end
            TUZ: begin
                if (w_faz_son) begin
                    w_doz_bitti = 1'b1;
                    if (r_kalan == 4'd0) begin
                        w_durum_nxt = BITIR;
                    end else if (BOSLUK == 0) begin
                        w_durum_nxt   = ACIK;
                        w_yukle       = 1'b1;
                        w_yukle_deger = ACIK_YUK;
                    end else begin
                        w_durum_nxt   = ARA;
                        w_yukle       = 1'b1;
                        w_yukle_deger = ARA_YUK;
                    end
                end
            end
            ACIK: begin
                if (w_faz_son) begin
                    w_doz_bitti   = 1'b1;
                    w_kalan_azalt = 1'b1;
                    // Last unit goes straight to BITIR: no trailing gap.
                    if (r_kalan == 4'd1) begin
                        w_durum_nxt = BITIR;
                    end else if (BOSLUK == 0) begin
                        w_durum_nxt   = ACIK;
                        w_yukle       = 1'b1;
                        w_yukle_deger = ACIK_YUK;
                    end else begin
                        w_durum_nxt   = ARA;
                        w_yukle       = 1'b1;
                        w_yukle_deger = ARA_YUK;
                    end
                end
            end
            ARA: begin
                if (w_faz_son) begin
                    w_durum_nxt   = ACIK;
                    w_yukle       = 1'b1;
                    w_yukle_deger = ACIK_YUK;
                end
            end
            BITIR: begin
                w_durum_nxt = BOSTA;
            end
            default: begin
                w_durum_nxt = BOSTA;
            end
        endcase
    end

    // Order capture and remaining-unit bookkeeping.
    always_ff @(posedge saat or posedge reset) begin
        if (reset) begin
            r_sel   <= 1'b0;
            r_kalan <= 4'd0;
        end else if (w_yakala) begin
            r_sel   <= siparis.secilen_malzeme;
            r_kalan <= siparis.malzeme_miktari;
        end else if (w_kalan_azalt) begin
            r_kalan <= r_kalan - 4'd1;
        end
    end

`ifdef DAGITICI_SAYAC_EN
    logic [7:0] r_toplam;

    // Lifetime dose counter, saturating at 255, cleared only by reset.
    always_ff @(posedge saat or posedge reset) begin
        if (reset) begin
            r_toplam <= 8'd0;
        end else if (w_doz_bitti && (r_toplam != 8'hFF)) begin
            r_toplam <= r_toplam + 8'd1;
        end
    end

    assign toplam_doz = r_toplam;
`endif

    // Outputs decode the registered state; reset forces BOSTA so valves drop at once.
    assign vana          = ((r_durum == ACIK) && !durdur) ? tek_sicak(r_sel) : 2'b00;
    assign tuz_vana      = (r_durum == TUZ) && !durdur;
    assign kalan         = r_kalan;
    assign tamam         = (r_durum == BITIR);
    assign siparis.hazir = (r_durum == BOSTA);

endmodule

// File: tb/tb_malzeme_dagitici.sv
// Directed bench for malzeme_dagitici with VANA_ACIK=2, BOSLUK=1.
// Inputs change #1 after the rising edge; outputs are sampled on the falling edge.
// Cycle k of an order is the k-th falling edge after its capture edge.
module tb_malzeme_dagitici;
    import dagitici_pkg::*;

    logic       saat = 1'b0;
    logic       reset = 1'b1;
    logic       durdur = 1'b0;
    logic [1:0] vana;
    logic       tuz_vana;
    logic [3:0] kalan;
    logic       tamam;
`ifdef DAGITICI_SAYAC_EN
    logic [7:0] toplam_doz;
`endif

    int n_vec  = 0;
    int n_hata = 0;

    malzeme_dagitici_if sip ();

    malzeme_dagitici #(.VANA_ACIK(2), .BOSLUK(1)) dut (
        .saat     (saat),
        .reset    (reset),
        .siparis  (sip),
        .durdur   (durdur),
        .vana     (vana),
        .tuz_vana (tuz_vana),
        .kalan    (kalan),
        .tamam    (tamam)
`ifdef DAGITICI_SAYAC_EN
        ,
        .toplam_doz (toplam_doz)
`endif
    );

    always #5 saat = ~saat;

    // Present one order and return #1 after its capture edge (cycle 1 begins).
    task automatic siparis_ver(input logic sel, input logic [3:0] n, input logic tz);
        int bekle;
        bekle = 0;
        @(negedge saat);
        while (sip.hazir !== 1'b1 && bekle < 50) begin
            @(negedge saat);
            bekle++;
        end
        n_vec++;
        if (sip.hazir !== 1'b1) begin
            n_hata++;
            $display("FAIL hazir_timeout: hazir=%b required 1", sip.hazir);
        end
        sip.secilen_malzeme = sel;
        sip.malzeme_miktari = n;
        sip.cikis_tuzlu     = tz;
        sip.bitti_giris     = 1'b1;
        @(posedge saat);
        #1;
        sip.bitti_giris     = 1'b0;
    endtask

    // Observe an order from cycle 1 until the cycle after tamam (or the limit).
    task automatic izle(input int sinir, input logic sel, input int d_bas, input int d_uz,
                        output int t_cyc, output int t_say, output int v_cyc,
                        output int v_pencere, output int tz_cyc, output int ihlal,
                        output int k_ilk, output int k_adim, output logic h_sonra);
        logic [1:0] onceki_v;
        logic [3:0] onceki_k;
        logic [1:0] bek_v;
        bek_v = sel ? 2'b10 : 2'b01;
        onceki_v = 2'b00; onceki_k = 4'd0;
        t_cyc = -1; t_say = 0; v_cyc = 0; v_pencere = 0; tz_cyc = 0;
        ihlal = 0; k_ilk = -1; k_adim = 0; h_sonra = 1'b0;
        for (int c = 1; c <= sinir; c++) begin
            durdur = (c >= d_bas) && (c < d_bas + d_uz);
            @(negedge saat);
            if (c == 1) k_ilk = int'(kalan);
            else if (kalan != onceki_k) begin
                if (kalan == 4'(onceki_k - 4'd1)) k_adim++;
                else ihlal++;
            end
            onceki_k = kalan;
            if (vana != 2'b00) v_cyc++;
            if (vana != 2'b00 && onceki_v == 2'b00) v_pencere++;
            if (vana != 2'b00 && vana != bek_v) ihlal++;
            if (vana != 2'b00 && tuz_vana) ihlal++;
            if (durdur && (vana != 2'b00 || tuz_vana)) ihlal++;
            if (tuz_vana) tz_cyc++;
            if (tamam) begin
                t_say++;
                if (t_cyc < 0) t_cyc = c;
            end
            onceki_v = vana;
            if (t_cyc > 0 && c == t_cyc + 1) begin
                h_sonra = sip.hazir;
                break;
            end
            @(posedge saat);
            #1;
        end
        durdur = 1'b0;
    endtask

    task automatic test_reset();
        sip.bitti_giris = 1'b0; sip.secilen_malzeme = 1'b0;
        sip.malzeme_miktari = 4'd0; sip.cikis_tuzlu = 1'b0;
        reset = 1'b1;
        @(negedge saat);
        n_vec++; if (sip.hazir !== 1'b1) begin n_hata++; $display("FAIL rst_hazir: got %b need 1", sip.hazir); end
        n_vec++; if (vana !== 2'b00) begin n_hata++; $display("FAIL rst_vana: got %b need 00", vana); end
        n_vec++; if (tuz_vana !== 1'b0) begin n_hata++; $display("FAIL rst_tuz: got %b need 0", tuz_vana); end
        n_vec++; if (kalan !== 4'd0) begin n_hata++; $display("FAIL rst_kalan: got %0d need 0", kalan); end
        n_vec++; if (tamam !== 1'b0) begin n_hata++; $display("FAIL rst_tamam: got %b need 0", tamam); end
`ifdef DAGITICI_SAYAC_EN
        n_vec++; if (toplam_doz !== 8'd0) begin n_hata++; $display("FAIL rst_toplam: got %0d need 0", toplam_doz); end
`endif
        @(negedge saat);
        reset = 1'b0;
    endtask

    task automatic test_yedi_birim();
        int t, ts, vc, vp, tc, ih, ki, ka; logic hs;
        siparis_ver(1'b1, 4'd7, 1'b0);
        izle(40, 1'b1, 0, 0, t, ts, vc, vp, tc, ih, ki, ka, hs);
        n_vec++; if (t != 21) begin n_hata++; $display("FAIL n7_tamam_cycle: got %0d need 21", t); end
        n_vec++; if (ts != 1) begin n_hata++; $display("FAIL n7_tamam_count: got %0d need 1", ts); end
        n_vec++; if (vc != 14) begin n_hata++; $display("FAIL n7_vana_cycles: got %0d need 14", vc); end
        n_vec++; if (vp != 7) begin n_hata++; $display("FAIL n7_vana_windows: got %0d need 7", vp); end
        n_vec++; if (ki != 7) begin n_hata++; $display("FAIL n7_kalan_first: got %0d need 7", ki); end
        n_vec++; if (ka != 7) begin n_hata++; $display("FAIL n7_kalan_steps: got %0d need 7", ka); end
        n_vec++; if (tc != 0) begin n_hata++; $display("FAIL n7_tuz_cycles: got %0d need 0", tc); end
        n_vec++; if (ih != 0) begin n_hata++; $display("FAIL n7_violations: got %0d need 0", ih); end
        n_vec++; if (hs !== 1'b1) begin n_hata++; $display("FAIL n7_hazir_after: got %b need 1", hs); end
    endtask

    task automatic test_tuz_sifir();
        int t, ts, vc, vp, tc, ih, ki, ka; logic hs;
        siparis_ver(1'b0, 4'd0, 1'b1);
        izle(20, 1'b0, 0, 0, t, ts, vc, vp, tc, ih, ki, ka, hs);
        n_vec++; if (t != 3) begin n_hata++; $display("FAIL salt_tamam_cycle: got %0d need 3", t); end
        n_vec++; if (tc != 2) begin n_hata++; $display("FAIL salt_tuz_cycles: got %0d need 2", tc); end
        n_vec++; if (vc != 0) begin n_hata++; $display("FAIL salt_vana_cycles: got %0d need 0", vc); end
        n_vec++; if (ki != 0 || ka != 0) begin n_hata++; $display("FAIL salt_kalan: first %0d steps %0d need 0/0", ki, ka); end
        n_vec++; if (ih != 0) begin n_hata++; $display("FAIL salt_violations: got %0d need 0", ih); end
    endtask

    task automatic test_sifir_siparis();
        int t, ts, vc, vp, tc, ih, ki, ka; logic hs;
        siparis_ver(1'b0, 4'd0, 1'b0);
        izle(10, 1'b0, 0, 0, t, ts, vc, vp, tc, ih, ki, ka, hs);
        n_vec++; if (t != 1) begin n_hata++; $display("FAIL zero_tamam_cycle: got %0d need 1", t); end
        n_vec++; if (vc != 0 || tc != 0) begin n_hata++; $display("FAIL zero_valves: vana %0d tuz %0d need 0/0", vc, tc); end
        n_vec++; if (hs !== 1'b1) begin n_hata++; $display("FAIL zero_hazir_after: got %b need 1", hs); end
    endtask

    task automatic test_durdur();
        int t, ts, vc, vp, tc, ih, ki, ka; logic hs;
        // Units: salt 1-2, gap 3, unit1 4-5, gap 6, unit2 7-8 (paused 8..11), ...
        siparis_ver(1'b0, 4'd3, 1'b1);
        izle(40, 1'b0, 8, 4, t, ts, vc, vp, tc, ih, ki, ka, hs);
        n_vec++; if (t != 16) begin n_hata++; $display("FAIL pause_tamam_cycle: got %0d need 16", t); end
        n_vec++; if (vc != 6) begin n_hata++; $display("FAIL pause_vana_cycles: got %0d need 6", vc); end
        n_vec++; if (vp != 4) begin n_hata++; $display("FAIL pause_vana_windows: got %0d need 4", vp); end
        n_vec++; if (tc != 2) begin n_hata++; $display("FAIL pause_tuz_cycles: got %0d need 2", tc); end
        n_vec++; if (ka != 3) begin n_hata++; $display("FAIL pause_kalan_steps: got %0d need 3", ka); end
        n_vec++; if (ih != 0) begin n_hata++; $display("FAIL pause_violations: got %0d need 0", ih); end
    endtask

    task automatic test_reset_orta();
        int t, ts, vc, vp, tc, ih, ki, ka; logic hs;
        int tamam_say;
        siparis_ver(1'b1, 4'd6, 1'b0);
        repeat (4) @(posedge saat);
        #1;
        n_vec++; if (vana !== 2'b10) begin n_hata++; $display("FAIL midrst_vana_before: got %b need 10", vana); end
        reset = 1'b1;
        #1;
        n_vec++; if (vana !== 2'b00) begin n_hata++; $display("FAIL midrst_vana_async: got %b need 00", vana); end
        n_vec++; if (sip.hazir !== 1'b1) begin n_hata++; $display("FAIL midrst_hazir: got %b need 1", sip.hazir); end
        n_vec++; if (kalan !== 4'd0) begin n_hata++; $display("FAIL midrst_kalan: got %0d need 0", kalan); end
        tamam_say = 0;
        repeat (2) begin
            @(negedge saat);
            if (tamam) tamam_say++;
        end
        reset = 1'b0;
        repeat (20) begin
            @(negedge saat);
            if (tamam) tamam_say++;
        end
        n_vec++; if (tamam_say != 0) begin n_hata++; $display("FAIL midrst_no_tamam: got %0d pulses need 0", tamam_say); end
        siparis_ver(1'b1, 4'd1, 1'b0);
        izle(20, 1'b1, 0, 0, t, ts, vc, vp, tc, ih, ki, ka, hs);
        n_vec++; if (t != 3) begin n_hata++; $display("FAIL midrst_next_tamam: got %0d need 3", t); end
        n_vec++; if (vc != 2) begin n_hata++; $display("FAIL midrst_next_vana: got %0d need 2", vc); end
    endtask

    task automatic test_back_to_back();
        int t1, t2, bekle;
        logic h4, h5;
        logic [1:0] v5;
        t1 = -1; t2 = -1; h4 = 1'b0; h5 = 1'b1; v5 = 2'b00; bekle = 0;
        sip.secilen_malzeme = 1'b0;
        sip.malzeme_miktari = 4'd1;
        sip.cikis_tuzlu     = 1'b0;
        @(negedge saat);
        while (sip.hazir !== 1'b1 && bekle < 50) begin
            @(negedge saat);
            bekle++;
        end
        sip.bitti_giris = 1'b1;
        @(posedge saat);
        #1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge saat);
            if (tamam) begin
                if (t1 < 0) t1 = c;
                else if (t2 < 0) t2 = c;
            end
            if (c == 4) h4 = sip.hazir;
            if (c == 5) begin h5 = sip.hazir; v5 = vana; end
            if (c < 7) begin
                @(posedge saat);
                #1;
            end
        end
        sip.bitti_giris = 1'b0;
        n_vec++; if (t1 != 3) begin n_hata++; $display("FAIL b2b_first_tamam: got %0d need 3", t1); end
        n_vec++; if (h4 !== 1'b1) begin n_hata++; $display("FAIL b2b_hazir_c4: got %b need 1", h4); end
        n_vec++; if (h5 !== 1'b0) begin n_hata++; $display("FAIL b2b_hazir_c5: got %b need 0", h5); end
        n_vec++; if (v5 !== 2'b01) begin n_hata++; $display("FAIL b2b_vana_c5: got %b need 01", v5); end
        n_vec++; if (t2 != 7) begin n_hata++; $display("FAIL b2b_second_tamam: got %0d need 7", t2); end
        @(negedge saat);
    endtask

`ifdef DAGITICI_SAYAC_EN
    task automatic test_sayac();
        int t, ts, vc, vp, tc, ih, ki, ka; logic hs;
        @(posedge saat);
        #1;
        reset = 1'b1;
        @(negedge saat);
        n_vec++; if (toplam_doz !== 8'd0) begin n_hata++; $display("FAIL cnt_clear: got %0d need 0", toplam_doz); end
        reset = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            siparis_ver(1'b0, 4'd7, 1'b0);
            izle(40, 1'b0, 0, 0, t, ts, vc, vp, tc, ih, ki, ka, hs);
            if (k == 1) begin
                n_vec++; if (toplam_doz !== 8'd7) begin n_hata++; $display("FAIL cnt_after_1: got %0d need 7", toplam_doz); end
            end
            if (k == 36) begin
                n_vec++; if (toplam_doz !== 8'd252) begin n_hata++; $display("FAIL cnt_after_36: got %0d need 252", toplam_doz); end
            end
        end
        n_vec++; if (toplam_doz !== 8'd255) begin n_hata++; $display("FAIL cnt_saturate: got %0d need 255", toplam_doz); end
    endtask
`endif

    initial begin
        test_reset();
        test_yedi_birim();
        test_tuz_sifir();
        test_sifir_siparis();
        test_durdur();
        test_reset_orta();
        test_back_to_back();
`ifdef DAGITICI_SAYAC_EN
        test_sayac();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_hata);
        $finish;
    end

endmodule
